dds_sweep_ctrl: RTL and testbench

Controller for the DDS sine datapath. It owns the phase accumulator and a byte-wide configuration register file, and produces the 14-bit phase word that feeds the sine lookup. It runs either a fixed tone or a linear frequency sweep between two tuning words, with a programmable dwell time per step. It sits between the top-level pin wrapper (config bytes arrive on `ui_in`/`uio_in`) and the sine block.

---
 rtl/dds_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: config register file, phase accumulator and tone/sweep FSM.
// Emits the phase word for the sine lookup, with a programmable offset added.
module dds_sweep_ctrl #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned PHASE_W = 14
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic               wr_en_i,
  input  logic [2:0]         wr_addr_i,
  input  logic [7:0]         wr_data_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [PHASE_W-1:0] phase_out_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {StIdle, StTone, StSweep, StDone} state_e;

  // Config register file
  logic [ACC_W-1:0] ftw_start_q, ftw_stop_q;
  logic [7:0]       step_q, dwell_q, pofs_q;
  logic [1:0]       ctrl_q;

  // Datapath / FSM state
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_cur_q, ftw_cur_d;
  logic [7:0]       dwell_cnt_q, dwell_cnt_d;

  logic [ACC_W:0]   step_sum;
  logic             mode_sweep, loop_en;

  assign mode_sweep = ctrl_q[0];
  assign loop_en    = ctrl_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ftw_start_q <= '0;
      ftw_stop_q  <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      ctrl_q      <= '0;
      pofs_q      <= '0;
    end else if (wr_en_i) begin
      unique case (wr_addr_i)
        3'd0:    ftw_start_q[7:0]       <= wr_data_i;
        3'd1:    ftw_start_q[ACC_W-1:8] <= wr_data_i[ACC_W-9:0];
        3'd2:    ftw_stop_q[7:0]        <= wr_data_i;
        3'd3:    ftw_stop_q[ACC_W-1:8]  <= wr_data_i[ACC_W-9:0];
        3'd4:    step_q                 <= wr_data_i;
        3'd5:    dwell_q                <= wr_data_i;
        3'd6:    ctrl_q                 <= wr_data_i[1:0];
        default: pofs_q                 <= wr_data_i;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ftw_cur_q   <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ftw_cur_q   <= ftw_cur_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  // Extra MSB keeps the step sum from wrapping before the clamp compare.
  assign step_sum = {1'b0, ftw_cur_q} + {{(ACC_W-7){1'b0}}, step_q};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ftw_cur_d   = ftw_cur_q;
    dwell_cnt_d = dwell_cnt_q;
    if (ena_i) begin
      if (stop_i) begin
        state_d = StIdle;
        acc_d   = '0;
      end else if (start_i) begin
        acc_d       = '0;
        ftw_cur_d   = ftw_start_q;
        dwell_cnt_d = '0;
        state_d     = mode_sweep ? StSweep : StTone;
      end else begin
        unique case (state_q)
          StIdle: begin
            acc_d = acc_q;
          end
          StTone: begin
            acc_d = acc_q + ftw_start_q;
          end
          StSweep: begin
            acc_d = acc_q + ftw_cur_q;
            if (dwell_cnt_q == dwell_q) begin
              dwell_cnt_d = '0;
              if (ftw_cur_q >= ftw_stop_q) begin
                if (loop_en) ftw_cur_d = ftw_start_q;
                else         state_d   = StDone;
              end else if (step_sum > {1'b0, ftw_stop_q}) begin
                ftw_cur_d = ftw_stop_q;
              end else begin
                ftw_cur_d = step_sum[ACC_W-1:0];
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q + 8'd1;
            end
          end
          StDone: begin
            acc_d = acc_q + ftw_cur_q;
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  assign phase_out_o = acc_q[ACC_W-1 -: PHASE_W] + {pofs_q, {(PHASE_W-8){1'b0}}};
  assign busy_o      = (state_q == StTone) || (state_q == StSweep);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected {busy, done, phase} per cycle is queued
// from a tuning-word schedule and compared against the DUT each cycle.
module tb_dds_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, ena, wr_en, start, stop;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [13:0] phase_out;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] wsched[$];

  dds_sweep_ctrl #(.ACC_W(16), .PHASE_W(14)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ena_i      (ena),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .start_i    (start),
    .stop_i     (stop),
    .phase_out_o(phase_out),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Queue samples j=0..n; ena is low for the edges feeding samples frz_from+1..frz_from+frz_len.
  task automatic push_sched(input int n, input int done_at, input int frz_from, input int frz_len);
    logic [15:0] accs[$];
    logic [15:0] a;
    int k;
    logic d;
    a = 16'h0;
    accs.push_back(a);
    for (int i = 0; i < n; i++) begin
      a = a + wsched[i];
      accs.push_back(a);
    end
    for (int j = 0; j <= n; j++) begin
      if (j <= frz_from) k = j;
      else if (j <= frz_from + frz_len) k = frz_from;
      else k = j - frz_len;
      d = (done_at >= 0) && (k >= done_at);
      a = accs[k];
      sb_q.push_back({~d, d, a[15:2]});
    end
  endtask

  task automatic sched_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4, input int nw,
                             input int per, input int total_len, input bit repeat_all);
    logic [15:0] ws[5];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3; ws[4] = w4;
    wsched.delete();
    for (int i = 0; i < total_len; i++) begin
      if (repeat_all) wsched.push_back(ws[(i / per) % nw]);
      else if (i / per < nw) wsched.push_back(ws[i / per]);
      else wsched.push_back(ws[nw-1]);
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    obs = {busy, done, 14'(phase_out)};
    total++;
    if (obs !== 16'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, 16'h0);
    end
  endtask

  task automatic test_tone();
    logic [15:0] obs, exp;
    wr(3'd0, 8'h00); wr(3'd1, 8'h04); wr(3'd7, 8'h00); wr(3'd6, 8'h00);
    pulse_start();
    for (int k = 0; k <= 70; k++) sb_q.push_back({2'b10, 14'((k * 32'h100) & 32'h3FFF)});
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tone k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    sb_q.push_back({2'b10, 14'((71 * 32'h100 + 32'h1000) & 32'h3FFF)});
    wr(3'd7, 8'h40);
    exp = sb_q.pop_front();
    obs = {busy, done, phase_out};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL tone_pofs got=%h want=%h", obs, exp);
    end
    // Asynchronous reset mid-tone
    rst_n = 1'b0;
    #2;
    obs = {busy, done, phase_out};
    total++;
    if (obs !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_tone got=%h want=%h", obs, 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      cyc();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== 16'h8000) begin
        bad++;
        $display("FAIL reset_regs_zero k=%0d got=%h want=%h", k, obs, 16'h8000);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] obs, exp;
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h00); wr(3'd3, 8'h03);
    wr(3'd4, 8'h80); wr(3'd5, 8'd3); wr(3'd6, 8'h01);
    sched_words(16'h100, 16'h180, 16'h200, 16'h280, 16'h300, 5, 4, 40, 1'b0);
    push_sched(40, 20, 40, 0);
    pulse_start();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL oneshot k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_loop();
    logic [15:0] obs, exp;
    wr(3'd4, 8'hC0); wr(3'd6, 8'h03);
    sched_words(16'h100, 16'h1C0, 16'h280, 16'h300, 16'h0, 4, 4, 48, 1'b1);
    push_sched(48, -1, 48, 0);
    pulse_start();
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL loop k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_start_stop_ena();
    logic [15:0] obs, exp;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    obs = {busy, done, phase_out};
    total++;
    if (obs !== 16'h0) begin
      bad++;
      $display("FAIL start_stop_same got=%h want=%h", obs, 16'h0);
    end
    wr(3'd4, 8'h80); wr(3'd6, 8'h01);
    sched_words(16'h100, 16'h180, 16'h200, 16'h280, 16'h300, 5, 4, 40, 1'b0);
    push_sched(36, 20, 6, 5);
    pulse_start();
    for (int j = 0; j <= 36; j++) begin
      if (j > 0) begin
        ena = !(j > 6 && j <= 11);
        cyc();
      end
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ena_freeze j=%0d got=%h want=%h", j, obs, exp);
      end
    end
    ena = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] obs, exp;
    pulse_start();
    repeat (6) cyc();
    // Restart mid-sweep together with a FTW_START write: the old value must be loaded.
    sched_words(16'h100, 16'h180, 16'h200, 16'h280, 16'h300, 5, 4, 24, 1'b0);
    push_sched(24, 20, 24, 0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h40; start = 1'b1;
    cyc();
    wr_en = 1'b0; start = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL restart k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    pulse_start();
    cyc();
    obs = {busy, done, phase_out};
    total++;
    if (obs !== {2'b10, 14'h50}) begin
      bad++;
      $display("FAIL new_ftw_start got=%h want=%h", obs, {2'b10, 14'h50});
    end
  endtask

  task automatic test_edge();
    logic [15:0] obs, exp;
    wr(3'd0, 8'h00); wr(3'd1, 8'h03); wr(3'd2, 8'h00); wr(3'd3, 8'h01);
    sched_words(16'h300, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4, 12, 1'b0);
    push_sched(12, 4, 12, 0);
    pulse_start();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL stop_lt_start k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    wr(3'd1, 8'h01); wr(3'd3, 8'h03); wr(3'd4, 8'h00);
    sched_words(16'h100, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4, 1000, 1'b0);
    push_sched(1000, -1, 1000, 0);
    pulse_start();
    for (int k = 0; k <= 1000; k++) begin
      if (k > 0) cyc();
      exp = sb_q.pop_front();
      obs = {busy, done, phase_out};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL step_zero k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h0;
    start = 1'b0; stop = 1'b0;
    #12;
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_tone();
    test_oneshot();
    test_loop();
    test_start_stop_ena();
    test_back_to_back();
    test_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
